// File: rtl/reg_file_sb.sv
// Register file with async read ports, a sequenced clear sweep and a RAW pending scoreboard.
// Ports: clk/rst (sync, active-high); clr_req/busy for the clear sweep; read ports A/B
// (rd_addr_x -> rd_data_x, pend_x, combinational); write port (wr_en/wr_addr/wr_data,
// which also retires the pending bit); issue port (iss_en/iss_addr, which marks an entry pending).
// Optional write-through bypass on the read ports: define RF_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] ptr, nextPtr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wrOk, issOk;

  // Entry 0 is read-only zero when ZERO_REG is set.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  function automatic logic [DATA_W-1:0] readMem(input logic [ADDR_W-1:0] a);
    return writable(a) ? mem[a] : '0;
  endfunction

  // Holding busy high during rst as well keeps every side effect blocked until the sweep ends.
  assign busy  = rst || (state == CLEAR);
  assign wrOk  = !busy && wr_en && writable(wr_addr);
  assign issOk = !busy && iss_en && writable(iss_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= nextState;
      ptr   <= nextPtr;
    end
  end

  // A clr_req arriving during CLEAR falls through untouched: no restart, no queueing.
  always_comb begin
    nextState = state;
    nextPtr   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          nextState = CLEAR;
          nextPtr   = '0;
        end
      end
      CLEAR: begin
        nextPtr = ptr + ADDR_W'(1);
        if (ptr == {ADDR_W{1'b1}}) nextState = IDLE;
      end
      default: begin
        nextState = CLEAR;
        nextPtr   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst) begin
      mem[ptr] <= '0;
    end else if (wrOk) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Set is applied after clear so a same-edge reissue to a retiring entry stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        pend <= '0;
      end else begin
        if (wrOk)  pend[wr_addr]  <= 1'b0;
        if (issOk) pend[iss_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    pend_a    = 1'b0;
    if (!busy) begin
      rd_data_a = readMem(rd_addr_a);
      pend_a    = pend[rd_addr_a];
`ifdef RF_BYPASS_EN
      if (wrOk && wr_addr == rd_addr_a) begin
        rd_data_a = wr_data;
        pend_a    = issOk && (iss_addr == rd_addr_a);
      end
`endif
    end
  end

  always_comb begin
    rd_data_b = '0;
    pend_b    = 1'b0;
    if (!busy) begin
      rd_data_b = readMem(rd_addr_b);
      pend_b    = pend[rd_addr_b];
`ifdef RF_BYPASS_EN
      if (wrOk && wr_addr == rd_addr_b) begin
        rd_data_b = wr_data;
        pend_b    = issOk && (iss_addr == rd_addr_b);
      end
`endif
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's 32x32 register file: 2 async read ports, 1 sync write port, optional hardwired-zero register 0.
- Adds a sequenced clear engine: one entry zeroed per cycle, with a `busy` flag, replacing the flash reset.
- Adds a per-register pending scoreboard so the control unit can detect RAW hazards on in-flight writes.
- Sits between decode (read/issue) and writeback (write/retire) in the R/I/J datapath.

Parameters:
- DATA_W, default 32: register width in bits.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, default 1: 1 = entry 0 reads 0, is never written and is never pending; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request a full clear sweep; single-cycle pulse.
- busy  out  1  clear sweep in progress.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data (combinational).
- pend_a  out  1  entry at rd_addr_a has an outstanding write.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data (combinational).
- pend_b  out  1  entry at rd_addr_b has an outstanding write.
- wr_en  in  1  write strobe; also retires the pending bit for wr_addr.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- iss_en  in  1  mark iss_addr pending (producer issued).
- iss_addr  in  ADDR_W  destination register being issued.

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous and active-high.
  - While rst=1: state=CLEAR, ptr=0, all pending bits=0, busy=1.
  - rst=1 mid-sweep restarts the sweep at ptr=0.
- State machine, IDLE / CLEAR:
  - CLEAR, each edge with rst=0: mem[ptr]<=0, ptr<=ptr+1.
  - When ptr==DEPTH-1 is cleared: state<=IDLE, busy<=0.
  - After rst falls, busy stays high for exactly DEPTH cycles.
  - IDLE and clr_req=1: next state=CLEAR, ptr=0, busy=1, all pending bits cleared on the same edge.
  - clr_req during CLEAR is ignored; the sweep is not restarted and the request is not queued.
- During busy=1:
  - wr_en and iss_en are ignored: no memory write, no scoreboard change.
  - rd_data_a/b=0 and pend_a/b=0.
- Write, IDLE:
  - wr_en=1 with writable wr_addr: mem[wr_addr]<=wr_data on the edge; visible on reads the next cycle.
  - With ZERO_REG=1, wr_addr=0 is dropped.
- Read:
  - rd_data_x = mem[rd_addr_x], combinational, zero latency.
  - With ZERO_REG=1, address 0 always returns 0.
  - A and B may carry the same address.
- Scoreboard, DEPTH bits, IDLE only:
  - iss_en sets pend[iss_addr].
  - wr_en clears pend[wr_addr].
  - Same edge, same address: set wins (a newer producer is in flight).
  - With ZERO_REG=1, pend[0] is never set.
  - pend_x = pend[rd_addr_x], combinational.
  - wr_en to a non-pending entry is legal: data is written, bit stays 0.
  - iss_en to an already pending entry is legal: bit stays 1.
- Width rules: no truncation or extension; all addresses are exactly ADDR_W bits, so out-of-range addresses are impossible.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through bypass, applied per port when state is IDLE, wr_en=1, wr_addr==rd_addr_x and the address is writable. Then:
  - rd_data_x = wr_data in the same cycle.
  - pend_x = 0, unless iss_en=1 with iss_addr==rd_addr_x on that cycle, in which case pend_x=1.
- Not defined: reads return the pre-edge mem value and pre-edge pend bit; a same-cycle write is seen one cycle later.

Test Plan:
- Reset sweep, DEPTH=32:
  - Pulse rst for 2 cycles, then release.
  - busy=1 for exactly 32 cycles after release, then 0.
  - rd_addr_a=31 reads 0.
  - wr_en (addr 3, 0xDEADBEEF) during busy is dropped; addr 3 reads 0 after the sweep.
- Write/read plus zero register:
  - Write 0x12345678 to addr 5 → rd_data_a(5)=0x12345678 the next cycle.
  - Write 0xFFFFFFFF to addr 0 → rd_data_b(0)=0 with ZERO_REG=1; reads 0xFFFFFFFF with ZERO_REG=0.
- Scoreboard:
  - iss_en addr 7 → pend_a(7)=1 the next cycle.
  - wr_en addr 7 (0xA5) → pend_a=0 the next cycle and data=0xA5.
  - Same-edge iss_en and wr_en on addr 7 → pend=1 and data=0xA5.
- clr_req mid-operation:
  - Entries 1..4 written and 2 pending; pulse clr_req.
  - busy=1 for 32 cycles; pending bits cleared immediately.
  - After the sweep, all four entries read 0.
  - Second clr_req during the sweep does not extend busy.
- rst mid-sweep: assert rst at ptr=10 → sweep restarts; busy lasts 32 cycles from rst release.
- Bypass, same cycle: wr_en addr 9 = 0x55 with rd_addr_a=9:
  - RF_BYPASS_EN defined: rd_data_a=0x55 and pend_a=0.
  - RF_BYPASS_EN undefined: rd_data_a shows the old value that cycle and 0x55 the next.
